// File: rtl/axi_pkg.sv
// Shared AXI-lite definitions for the LSU master.
// Holds response codes and the master FSM state type.
package axi_pkg;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
  localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD_ADDR,
    S_RD_DATA,
    S_WR_REQ,
    S_WR_RESP,
    S_RESP
  } lsu_master_state_t;

endpackage

// File: rtl/lsu_axi_master.sv
// AXI-lite master: one core load/store in flight, mapped onto AR/R or AW/W/B.
// The response is held in RESP until the core takes it.
module lsu_axi_master
  import axi_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_wen,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [DATA_W-1:0]   req_wdata,
  input  logic [DATA_W/8-1:0] req_wstrb,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [DATA_W-1:0]   rsp_rdata,
  output logic                rsp_err,
  output logic [ADDR_W-1:0]   araddr,
  output logic                arvalid,
  input  logic                arready,
  input  logic [DATA_W-1:0]   rdata,
  input  logic [1:0]          rresp,
  input  logic                rvalid,
  output logic                rready,
  output logic [ADDR_W-1:0]   awaddr,
  output logic                awvalid,
  input  logic                awready,
  output logic [DATA_W-1:0]   wdata,
  output logic [DATA_W/8-1:0] wstrb,
  output logic                wvalid,
  input  logic                wready,
  input  logic [1:0]          bresp,
  input  logic                bvalid,
  output logic                bready
);

  localparam int STRB_W = DATA_W / 8;

  lsu_master_state_t state;
  lsu_master_state_t state_nx;

  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [STRB_W-1:0] wstrb_q;
  logic              wen_q;
  logic              aw_done;
  logic              w_done;

  logic aw_fire;
  logic w_fire;
  logic aw_ok;
  logic w_ok;
  logic accept;

  assign accept  = (state == S_IDLE) && req_valid;
  assign aw_fire = awvalid && awready;
  assign w_fire  = wvalid && wready;
  assign aw_ok   = aw_done || aw_fire;
  assign w_ok    = w_done || w_fire;

  // Every valid/ready is a pure decode of registered state.
  assign req_ready = (state == S_IDLE);
  assign arvalid   = (state == S_RD_ADDR);
  assign rready    = (state == S_RD_DATA);
  assign awvalid   = (state == S_WR_REQ) && !aw_done;
  assign wvalid    = (state == S_WR_REQ) && !w_done;
  assign bready    = (state == S_WR_RESP);
  assign rsp_valid = (state == S_RESP);

  assign araddr = addr_q;
  assign awaddr = addr_q;
  assign wdata  = wdata_q;
  assign wstrb  = wstrb_q;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next-state decode.
  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE: begin
        if (req_valid) begin
          state_nx = req_wen ? S_WR_REQ : S_RD_ADDR;
        end
      end
      S_RD_ADDR: begin
        if (arready) state_nx = S_RD_DATA;
      end
      S_RD_DATA: begin
        if (rvalid) state_nx = S_RESP;
      end
      S_WR_REQ: begin
        if (aw_ok && w_ok) state_nx = S_WR_RESP;
      end
      S_WR_RESP: begin
        if (bvalid) state_nx = S_RESP;
      end
      S_RESP: begin
        if (rsp_ready) state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // Request latch, loaded only when a request is accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q  <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
      wen_q   <= 1'b0;
    end else if (accept) begin
      addr_q  <= req_addr;
      wdata_q <= req_wdata;
      wstrb_q <= req_wstrb;
      wen_q   <= req_wen;
    end
  end

  // AW/W completion flags; cleared when both halves are done.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      aw_done <= 1'b0;
      w_done  <= 1'b0;
    end else if (state == S_WR_REQ) begin
      if (aw_ok && w_ok) begin
        aw_done <= 1'b0;
        w_done  <= 1'b0;
      end else begin
        if (aw_fire) aw_done <= 1'b1;
        if (w_fire)  w_done  <= 1'b1;
      end
    end
  end

  // Response capture from R or B; stores report zero data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else if ((state == S_RD_DATA) && rvalid) begin
      rsp_rdata <= rdata;
      rsp_err   <= (rresp != AXI_RESP_OKAY);
    end else if ((state == S_WR_RESP) && bvalid && wen_q) begin
      rsp_rdata <= '0;
      rsp_err   <= (bresp != AXI_RESP_OKAY);
    end
  end

endmodule

// File: tb/tb_lsu_axi_master.sv
// Bench for lsu_axi_master: transaction-level model plus directed tests.
// Slave and core responder are latency-programmable bench processes.
module tb_lsu_axi_master;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_wen;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_wstrb;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic [31:0] araddr;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;
  logic [31:0] awaddr;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wvalid;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;

  lsu_axi_master #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_wen(req_wen), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_wstrb(req_wstrb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .araddr(araddr), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
    .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%h exp=%h", nm, act, exp);
    end
  endtask

  // Slave / core-responder configuration.
  int          ar_lat = 0, r_lat = 0, aw_lat = 0, w_lat = 0, b_lat = 0;
  int          rsp_lat = 0;
  logic [31:0] cfg_rdata = '0;
  logic [1:0]  cfg_rresp = '0;
  logic [1:0]  cfg_bresp = '0;

  // Observations recorded at handshakes.
  int          n_rsp = 0, ar_n = 0, aw_n = 0, w_n = 0;
  logic [31:0] last_araddr, last_awaddr, last_wdata, last_rdata;
  logic [3:0]  last_wstrb;
  logic        last_err;
  int          hs_log[$];

  // Slave + core responder: drive at negedge, note handshakes before posedge.
  initial begin
    int ar_w, aw_w, w_w, rs_w, r_cnt, b_cnt;
    bit r_pend, b_pend, aw_got, w_got;
    ar_w = 0; aw_w = 0; w_w = 0; rs_w = 0; r_cnt = 0; b_cnt = 0;
    r_pend = 0; b_pend = 0; aw_got = 0; w_got = 0;
    arready = 0; rvalid = 0; rdata = '0; rresp = '0;
    awready = 0; wready = 0; bvalid = 0; bresp = '0; rsp_ready = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        ar_w = 0; aw_w = 0; w_w = 0; rs_w = 0;
        r_pend = 0; b_pend = 0; aw_got = 0; w_got = 0;
      end
      arready   = arvalid && (ar_w >= ar_lat);
      rvalid    = r_pend && (r_cnt == 0);
      rdata     = cfg_rdata;
      rresp     = cfg_rresp;
      awready   = awvalid && (aw_w >= aw_lat);
      wready    = wvalid && (w_w >= w_lat);
      bvalid    = b_pend && (b_cnt == 0);
      bresp     = cfg_bresp;
      rsp_ready = rsp_valid && (rs_w >= rsp_lat);
      #3;
      if (rst_n) begin
        if (arvalid && arready) begin
          ar_w = 0; r_pend = 1; r_cnt = r_lat;
          ar_n++; last_araddr = araddr; hs_log.push_back(1);
        end else if (arvalid) ar_w++;
        if (rvalid && rready) begin
          r_pend = 0; hs_log.push_back(2);
        end else if (r_pend && r_cnt != 0) r_cnt--;
        if (bvalid && bready) begin
          b_pend = 0; aw_got = 0; w_got = 0; hs_log.push_back(5);
        end else if (b_pend && b_cnt != 0) b_cnt--;
        if (awvalid && awready) begin
          aw_w = 0; aw_got = 1; aw_n++;
          last_awaddr = awaddr; hs_log.push_back(3);
        end else if (awvalid) aw_w++;
        if (wvalid && wready) begin
          w_w = 0; w_got = 1; w_n++;
          last_wdata = wdata; last_wstrb = wstrb; hs_log.push_back(4);
        end else if (wvalid) w_w++;
        if (aw_got && w_got && !b_pend && !(bvalid && bready)) begin
          b_pend = 1; b_cnt = b_lat;
        end
        if (rsp_valid && rsp_ready) begin
          rs_w = 0; n_rsp++;
          last_rdata = rsp_rdata; last_err = rsp_err;
        end else if (rsp_valid) rs_w++;
      end
    end
  end

  // Transaction-level model and per-cycle compare.
  int lat_q[$];
  int acc_q[$];
  initial begin
    bit o, m_wen, ar_d, aw_d, w_d, got, lat_seen;
    logic [31:0] m_addr, m_wdata, e_rdata;
    logic [3:0]  m_wstrb;
    logic        e_err;
    logic [6:0]  e_ctl, a_ctl;
    int cyc, acc_cyc;
    o = 0; m_wen = 0; ar_d = 0; aw_d = 0; w_d = 0; got = 0; lat_seen = 0;
    m_addr = '0; m_wdata = '0; m_wstrb = '0; e_rdata = '0; e_err = 0;
    cyc = 0; acc_cyc = 0;
    forever begin
      @(negedge clk);
      #3;
      cyc++;
      a_ctl = {req_ready, arvalid, rready, awvalid, wvalid, bready, rsp_valid};
      if (!rst_n) begin
        o = 0; ar_d = 0; aw_d = 0; w_d = 0; got = 0;
        chk("rst_ctl", 64'(a_ctl), 64'(7'b1000000));
      end else begin
        e_ctl = {!o,
                 o && !m_wen && !ar_d,
                 o && !m_wen && ar_d && !got,
                 o && m_wen && !aw_d,
                 o && m_wen && !w_d,
                 o && m_wen && aw_d && w_d && !got,
                 o && got};
        chk("ctl", 64'(a_ctl), 64'(e_ctl));
        if (e_ctl[5]) chk("araddr", 64'(araddr), 64'(m_addr));
        if (e_ctl[3]) chk("awaddr", 64'(awaddr), 64'(m_addr));
        if (e_ctl[2]) chk("wdata", 64'({wstrb, wdata}), 64'({m_wstrb, m_wdata}));
        if (e_ctl[0]) begin
          chk("rsp", 64'({rsp_err, rsp_rdata}), 64'({e_err, e_rdata}));
          if (!lat_seen) begin
            lat_seen = 1; lat_q.push_back(cyc - acc_cyc);
          end
        end
        if (e_ctl[0] && rsp_ready) begin
          o = 0; got = 0;
        end
        if (e_ctl[5] && arready) ar_d = 1;
        if (e_ctl[4] && rvalid) begin
          got = 1; e_rdata = rdata; e_err = (rresp != 2'b00);
        end
        if (e_ctl[3] && awready) aw_d = 1;
        if (e_ctl[2] && wready) w_d = 1;
        if (e_ctl[1] && bvalid) begin
          got = 1; e_rdata = '0; e_err = (bresp != 2'b00);
        end
        if (e_ctl[6] && req_valid) begin
          o = 1; m_wen = req_wen; m_addr = req_addr;
          m_wdata = req_wdata; m_wstrb = req_wstrb;
          ar_d = 0; aw_d = 0; w_d = 0; got = 0;
          acc_cyc = cyc; lat_seen = 0; acc_q.push_back(cyc);
        end
      end
    end
  end

  // Present a request and hold it until accepted.
  task automatic issue(input logic wen, input logic [31:0] a,
                       input logic [31:0] d, input logic [3:0] s);
    bit acc;
    int n;
    @(negedge clk);
    req_valid = 1; req_wen = wen; req_addr = a;
    req_wdata = d; req_wstrb = s;
    acc = 0; n = 0;
    while (!acc && n < 200) begin
      #3;
      acc = req_ready;
      @(negedge clk);
      n++;
    end
    req_valid = 0;
    if (!acc) chk("accept_timeout", 64'(0), 64'(1));
  endtask

  task automatic wait_rsp(input int target);
    int n;
    n = 0;
    while (n_rsp < target && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (n_rsp < target) chk("rsp_timeout", 64'(n_rsp), 64'(target));
  endtask

  initial begin
    int base, a0, w0;
    int exp_log[5];
    rst_n = 0; req_valid = 0; req_wen = 0;
    req_addr = '0; req_wdata = '0; req_wstrb = '0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_rdata", 64'(rsp_rdata), 64'(0));
    chk("rst_err", 64'(rsp_err), 64'(0));
    chk("rst_req_ready", 64'(req_ready), 64'(1));
    @(negedge clk);
    rst_n = 1;

    // Load with slow R data.
    ar_lat = 0; r_lat = 4; cfg_rdata = 32'hDEADBEEF; cfg_rresp = 2'b00;
    base = n_rsp;
    issue(1'b0, 32'h8000_0004, 32'h0, 4'h0);
    wait_rsp(base + 1);
    chk("t1_araddr", 64'(last_araddr), 64'h8000_0004);
    chk("t1_rdata", 64'(last_rdata), 64'hDEAD_BEEF);
    chk("t1_err", 64'(last_err), 64'(0));

    // Store, AW accepted three cycles before W.
    aw_lat = 0; w_lat = 3; b_lat = 1; cfg_bresp = 2'b00;
    base = n_rsp; a0 = aw_n; w0 = w_n;
    issue(1'b1, 32'h8000_0010, 32'h1234_5678, 4'b0011);
    wait_rsp(base + 1);
    chk("t2_aw_count", 64'(aw_n - a0), 64'(1));
    chk("t2_w_count", 64'(w_n - w0), 64'(1));
    chk("t2_awaddr", 64'(last_awaddr), 64'h8000_0010);
    chk("t2_wdata", 64'(last_wdata), 64'h1234_5678);
    chk("t2_wstrb", 64'(last_wstrb), 64'(4'b0011));
    chk("t2_rdata", 64'(last_rdata), 64'(0));
    chk("t2_err", 64'(last_err), 64'(0));

    // Store, AW and W together, SLVERR.
    w_lat = 0; b_lat = 0; cfg_bresp = 2'b10;
    base = n_rsp;
    issue(1'b1, 32'h8000_0020, 32'hA5A5_A5A5, 4'hF);
    wait_rsp(base + 1);
    chk("t3_err", 64'(last_err), 64'(1));
    chk("t3_rdata", 64'(last_rdata), 64'(0));

    // Slow core, DECERR load, second request queued behind it.
    rsp_lat = 5; cfg_rdata = 32'h0BAD_F00D; cfg_rresp = 2'b11;
    cfg_bresp = 2'b00; r_lat = 0;
    base = n_rsp;
    issue(1'b0, 32'h8000_0008, 32'h0, 4'h0);
    issue(1'b1, 32'h8000_000C, 32'h5555_AAAA, 4'hC);
    chk("t4_second_after_first", 64'(n_rsp), 64'(base + 1));
    chk("t4_rdata", 64'(last_rdata), 64'h0BAD_F00D);
    chk("t4_err", 64'(last_err), 64'(1));
    wait_rsp(base + 2);
    rsp_lat = 0; cfg_rresp = 2'b00;

    // Reset while AR is stalled.
    ar_lat = 100;
    issue(1'b0, 32'h8000_0080, 32'h0, 4'h0);
    repeat (3) @(negedge clk);
    chk("t5_arvalid_before", 64'(arvalid), 64'(1));
    #1 rst_n = 0;
    #1;
    chk("t5_arvalid_async", 64'(arvalid), 64'(0));
    chk("t5_req_ready", 64'(req_ready), 64'(1));
    repeat (2) @(negedge clk);
    rst_n = 1;
    ar_lat = 0; cfg_rdata = 32'hCAFE_F00D;
    base = n_rsp;
    issue(1'b0, 32'h8000_0084, 32'h0, 4'h0);
    wait_rsp(base + 1);
    chk("t5_rdata", 64'(last_rdata), 64'hCAFE_F00D);
    chk("t5_araddr", 64'(last_araddr), 64'h8000_0084);

    // Back-to-back load then store, everything ready.
    cfg_rdata = 32'h1111_2222;
    hs_log.delete(); lat_q.delete(); acc_q.delete();
    base = n_rsp;
    issue(1'b0, 32'h8000_0040, 32'h0, 4'h0);
    issue(1'b1, 32'h8000_0044, 32'h3333_4444, 4'hF);
    wait_rsp(base + 2);
    exp_log = '{1, 2, 3, 4, 5};
    chk("t6_log_size", 64'(hs_log.size()), 64'(5));
    for (int i = 0; i < 5; i++) begin
      if (i < hs_log.size()) chk("t6_log", 64'(hs_log[i]), 64'(exp_log[i]));
    end
    chk("t6_lat_count", 64'(lat_q.size()), 64'(2));
    if (lat_q.size() >= 2) begin
      chk("t6_lat_load", 64'(lat_q[0]), 64'(3));
      chk("t6_lat_store", 64'(lat_q[1]), 64'(3));
    end
    if (acc_q.size() >= 2) chk("t6_accept_gap", 64'(acc_q[1] - acc_q[0]), 64'(4));

    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout act=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/lsu_axi_master.md
Name: lsu_axi_master

Overview:
- AXI-lite master turning a single-outstanding core load/store request into AR/R or AW/W/B transactions.
- Sits between the LSU/IFU request port and any AXI-lite slave: instruction/data SRAM, UART, arbiter input.
- Exactly one transaction in flight; the response is held until the core accepts it.

Parameters:
- ADDR_W, 32, address width (matches `AXI_ADDR_BUS)
- DATA_W, 32, data width (matches `AXI_DATA_BUS); strobe width is DATA_W/8

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  core request valid
- req_ready  out  1  master can accept a request
- req_wen  in  1  1 = store, 0 = load
- req_addr  in  ADDR_W  byte address, passed to AXI unmodified
- req_wdata  in  DATA_W  store data
- req_wstrb  in  DATA_W/8  store byte enables
- rsp_valid  out  1  response valid
- rsp_ready  in  1  core accepts response
- rsp_rdata  out  DATA_W  load data; 0 for stores
- rsp_err  out  1  resp != OKAY
- araddr/arvalid/arready  out/out/in  ADDR_W/1/1  AR channel
- rdata/rresp/rvalid/rready  in/in/in/out  DATA_W/2/1/1  R channel
- awaddr/awvalid/awready  out/out/in  ADDR_W/1/1  AW channel
- wdata/wstrb/wvalid/wready  out/out/out/in  DATA_W/DATA_W/8/1/1  W channel
- bresp/bvalid/bready  in/in/out  2/1/1  B channel

Behaviour:
- Clock and reset (already decided): one clock, clk; reset rst_n, asynchronous, active-low.
- Reset: state IDLE.
  - arvalid, awvalid, wvalid, rready, bready, rsp_valid = 0.
  - rsp_rdata = 0, rsp_err = 0, aw_done = w_done = 0.
  - Latched addr/wdata/wstrb/wen = 0.
  - req_ready = 1 (decoded from IDLE), but a request is never captured while rst_n = 0.
- All AXI/rsp outputs are decoded from state plus registered latches; no combinational path from any input to any valid/ready output.
- States: IDLE, RD_ADDR, RD_DATA, WR_REQ, WR_RESP, RESP.
- IDLE:
  - req_ready = 1.
  - On req_valid: latch addr, wdata, wstrb, wen.
  - Next state is WR_REQ if wen, else RD_ADDR.
- RD_ADDR:
  - arvalid = 1, araddr = latched addr; both held stable until arready.
  - On arready, go to RD_DATA.
- RD_DATA:
  - rready = 1.
  - On rvalid: capture rdata into rsp_rdata, rsp_err = (rresp != 2'b00), go to RESP.
- WR_REQ:
  - awvalid = !aw_done, wvalid = !w_done; awaddr/wdata/wstrb come from the latches.
  - aw_done sets on awvalid&&awready; w_done sets on wvalid&&wready.
  - Leave to WR_RESP in the cycle both are complete, counting handshakes in the current cycle. Covers AW-before-W, W-before-AW and both in the same cycle.
  - aw_done and w_done clear on that transition.
- WR_RESP:
  - bready = 1.
  - On bvalid: rsp_err = (bresp != 2'b00), rsp_rdata = 0, go to RESP.
- RESP:
  - rsp_valid = 1; rsp_rdata/rsp_err held stable.
  - On rsp_ready, go to IDLE.
  - No new request is accepted in the same cycle; turnaround is one idle cycle.
- Minimum latency, slave always ready with 0-cycle data:
  - Load: 3 cycles from accept to rsp_valid (IDLE→RD_ADDR→RD_DATA→RESP).
  - Store: the same.
- Unbounded slave latency is tolerated; there is no timeout, and a valid is never dropped before its handshake (AXI rule).
- rvalid/bvalid arriving in a state that is not expecting them are ignored (slave protocol error, not handled).
- Reset asserted mid-transaction returns to IDLE immediately and drops all valids. The slave is reset by the same rst_n.
- resp SLVERR(10) and DECERR(11) both give rsp_err = 1. For reads, rdata is still forwarded.

Decomposition:
- Shared package axi_pkg:
  - resp constants AXI_RESP_OKAY=2'b00, AXI_RESP_SLVERR=2'b10, AXI_RESP_DECERR=2'b11.
  - lsu_master_state_t enum (3-bit) for the six states.
- Width macros stay in defines.svh.
- No sub-module; a single module of ~180 lines.

Test Plan:
- Load, slave arready=1 and rdata 0xDEADBEEF returned 4 cycles after AR → araddr=0x80000004 held until handshake, rsp_valid with rsp_rdata=0xDEADBEEF, rsp_err=0.
- Store addr 0x80000010, wdata 0x12345678, wstrb 0b0011; awready 3 cycles before wready → one AW and one W handshake, no re-issue; bresp=00 gives rsp_valid, rsp_err=0, rsp_rdata=0.
- Store with awready and wready high in the same cycle, then bvalid with bresp=2'b10 → WR_RESP next cycle, rsp_err=1.
- rsp_ready held low 5 cycles → rsp_valid and data stable, req_ready=0, a second req_valid is not accepted until RESP exits.
- rst_n pulsed low while arvalid=1 awaiting arready → arvalid=0 asynchronously, state IDLE, req_ready=1 after release, next load completes normally.
- Back-to-back load then store, slave always ready → each transaction takes 3 cycles accept-to-rsp_valid plus 1 turnaround; AXI handshake sequence matches the request order.
